// File: rtl/sad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sad_pkg
//  Brief    : Shared helpers for the SAD reduction tree: radix-4 log, width
//             derivation and flat tree-bus layout for every tree level.
//  Revision : 1.0  initial release
// ============================================================================
package sad_pkg;

  // Number of radix-4 levels needed to reduce n lanes down to one.
  function automatic int clog4(input int n);
    int v;
    int s;
    v = n;
    s = 0;
    while (v > 1) begin
      v = v / 4;
      s = s + 1;
    end
    return s;
  endfunction

  // True when n is an exact power of 4 no smaller than 4.
  function automatic bit is_pow4(input int n);
    int v;
    if (n < 4) return 1'b0;
    v = n;
    while (v > 1) begin
      if ((v % 4) != 0) return 1'b0;
      v = v / 4;
    end
    return 1'b1;
  endfunction

  // Width of a full single-beat sum: each level adds 2 carry bits.
  function automatic int sum_w(input int dw, input int n);
    return dw + 2 * clog4(n);
  endfunction

  // Accumulator width: single-beat sum plus headroom for multi-beat blocks.
  function automatic int acc_w(input int dw, input int n, input int extra);
    return sum_w(dw, n) + extra;
  endfunction

  // Bits occupied by tree level l (level 0 = raw lanes).
  function automatic int lvl_bits(input int n, input int dw, input int l);
    return (n >> (2 * l)) * (dw + 2 * l);
  endfunction

  // Offset of tree level l inside the packed bus holding all levels.
  function automatic int lvl_off(input int n, input int dw, input int l);
    int off;
    off = 0;
    for (int k = 0; k < l; k++) begin
      off = off + lvl_bits(n, dw, k);
    end
    return off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sad_add4_stage.sv
`default_nettype none
// ============================================================================
//  Module   : sad_add4_stage
//  Brief    : One registered radix-4 adder-tree level. Each group of four
//             IN_W lanes becomes one (a+b)+(c+d) lane of IN_W+2 bits; the
//             beat sideband travels alongside the data.
//  Revision : 1.0  initial release
// ============================================================================
module sad_add4_stage #(
  parameter int N_GRP = 1,
  parameter int IN_W  = 8,
  parameter int IDX_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [IDX_W-1:0]           in_idx,
  input  logic [N_GRP*4*IN_W-1:0]    in_data,
  output logic                       out_valid,
  output logic                       out_first,
  output logic                       out_last,
  output logic [IDX_W-1:0]           out_idx,
  output logic [N_GRP*(IN_W+2)-1:0]  out_data
);

  localparam int OUT_W = IN_W + 2;

  logic [N_GRP*OUT_W-1:0] data_d, data_q;
  logic                   valid_d, valid_q;
  logic                   first_d, first_q;
  logic                   last_d, last_q;
  logic [IDX_W-1:0]       idx_d, idx_q;

  // Pairwise sums per group; operands are zero-extended so nothing can wrap.
  always_comb begin
    data_d = '0;
    for (int g = 0; g < N_GRP; g++) begin
      data_d[g*OUT_W +: OUT_W] =
          (OUT_W'(in_data[(4*g)*IN_W +: IN_W])   + OUT_W'(in_data[(4*g+1)*IN_W +: IN_W]))
        + (OUT_W'(in_data[(4*g+2)*IN_W +: IN_W]) + OUT_W'(in_data[(4*g+3)*IN_W +: IN_W]));
    end
  end

  // Sideband is passed through unchanged, one level per cycle.
  always_comb begin
    valid_d = in_valid;
    first_d = in_first;
    last_d  = in_last;
    idx_d   = in_idx;
  end

  // Data path registers free-run; only the beat valid needs a reset.
  always_ff @(posedge clk) begin
    data_q  <= data_d;
    first_q <= first_d;
    last_q  <= last_d;
    idx_q   <= idx_d;
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_first = first_q;
  assign out_last  = last_q;
  assign out_idx   = idx_q;
  assign out_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/sad_tree_acc.sv
`default_nettype none
// ============================================================================
//  Module   : sad_tree_acc
//  Brief    : Pipelined SAD reduction. Registers N_IN AD lanes, reduces them
//             through a radix-4 registered adder tree, accumulates multi-beat
//             blocks with saturation and tracks the minimum-SAD candidate.
//  Revision : 1.0  initial release
// ============================================================================
module sad_tree_acc
  import sad_pkg::*;
#(
  parameter  int N_IN      = 64,
  parameter  int DW        = 8,
  parameter  int ACC_EXTRA = 4,
  parameter  int IDX_W     = 8,
  localparam int STG       = clog4(N_IN),
  localparam int SUM_W     = sum_w(DW, N_IN),
  localparam int ACC_W     = acc_w(DW, N_IN, ACC_EXTRA)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [N_IN*DW-1:0]   in_data,
  input  logic [IDX_W-1:0]     in_idx,
  input  logic                 search_clr,
  output logic                 out_valid,
  output logic [ACC_W-1:0]     out_sad,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 best_valid,
  output logic [ACC_W-1:0]     best_sad,
  output logic [IDX_W-1:0]     best_idx
);

  localparam bit N_IN_OK = is_pow4(N_IN);
  localparam int TREE_W  = lvl_off(N_IN, DW, STG + 1);

  if (!N_IN_OK) begin : g_bad_n_in
    $error("sad_tree_acc: N_IN must be a power of 4 and at least 4");
  end

  // ---------------------------------------------------------------- stage 0
  logic [N_IN*DW-1:0] s0_data_d, s0_data_q;
  logic               s0_valid_d, s0_valid_q;
  logic               s0_first_d, s0_first_q;
  logic               s0_last_d, s0_last_q;
  logic [IDX_W-1:0]   s0_idx_d, s0_idx_q;

  // Input capture: lanes and beat sideband taken as presented.
  always_comb begin
    s0_data_d  = in_data;
    s0_valid_d = in_valid;
    s0_first_d = in_first;
    s0_last_d  = in_last;
    s0_idx_d   = in_idx;
  end

  // Input registers; only the valid bit is reset.
  always_ff @(posedge clk) begin
    s0_data_q  <= s0_data_d;
    s0_first_q <= s0_first_d;
    s0_last_q  <= s0_last_d;
    s0_idx_q   <= s0_idx_d;
    if (rst) begin
      s0_valid_q <= 1'b0;
    end else begin
      s0_valid_q <= s0_valid_d;
    end
  end

  // ------------------------------------------------------------- adder tree
  // All tree levels live back-to-back in one bus; level l starts at
  // lvl_off(l), so every level keeps its exact width.
  logic [TREE_W-1:0] tree_bus;
  logic [STG:0]      lvl_valid;
  logic [STG:0]      lvl_first;
  logic [STG:0]      lvl_last;
  logic [IDX_W-1:0]  lvl_idx [0:STG];

  assign tree_bus[lvl_off(N_IN, DW, 0) +: lvl_bits(N_IN, DW, 0)] = s0_data_q;
  assign lvl_valid[0] = s0_valid_q;
  assign lvl_first[0] = s0_first_q;
  assign lvl_last[0]  = s0_last_q;
  assign lvl_idx[0]   = s0_idx_q;

  for (genvar s = 0; s < STG; s++) begin : g_stage
    localparam int IN_OFF   = lvl_off(N_IN, DW, s);
    localparam int IN_BITS  = lvl_bits(N_IN, DW, s);
    localparam int OUT_OFF  = lvl_off(N_IN, DW, s + 1);
    localparam int OUT_BITS = lvl_bits(N_IN, DW, s + 1);

    sad_add4_stage #(
      .N_GRP (N_IN >> (2 * (s + 1))),
      .IN_W  (DW + 2 * s),
      .IDX_W (IDX_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (lvl_valid[s]),
      .in_first  (lvl_first[s]),
      .in_last   (lvl_last[s]),
      .in_idx    (lvl_idx[s]),
      .in_data   (tree_bus[IN_OFF +: IN_BITS]),
      .out_valid (lvl_valid[s+1]),
      .out_first (lvl_first[s+1]),
      .out_last  (lvl_last[s+1]),
      .out_idx   (lvl_idx[s+1]),
      .out_data  (tree_bus[OUT_OFF +: OUT_BITS])
    );
  end

  logic [SUM_W-1:0] tree_sum;
  assign tree_sum = tree_bus[lvl_off(N_IN, DW, STG) +: SUM_W];

  // ------------------------------------------------------------ accumulator
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             open_d, open_q;
  logic             out_valid_d, out_valid_q;
  logic [ACC_W-1:0] out_sad_d, out_sad_q;
  logic [IDX_W-1:0] out_idx_d, out_idx_q;
  logic [ACC_W-1:0] tree_ext;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_sat;
  logic [ACC_W-1:0] acc_new;

  // Block accumulation: restart on first or when idle, saturate otherwise,
  // emit the block result on the last beat.
  always_comb begin
    acc_d       = acc_q;
    open_d      = open_q;
    out_valid_d = 1'b0;
    out_sad_d   = out_sad_q;
    out_idx_d   = out_idx_q;
    tree_ext    = ACC_W'(tree_sum);
    acc_sum     = {1'b0, acc_q} + {1'b0, tree_ext};
    acc_sat     = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    acc_new     = acc_q;
    if (lvl_valid[STG]) begin
      acc_new = (lvl_first[STG] || !open_q) ? tree_ext : acc_sat;
      acc_d   = acc_new;
      if (lvl_last[STG]) begin
        out_valid_d = 1'b1;
        out_sad_d   = acc_new;
        out_idx_d   = lvl_idx[STG];
        open_d      = 1'b0;
      end else begin
        open_d      = 1'b1;
      end
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      open_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sad_q   <= '0;
      out_idx_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      open_q      <= open_d;
      out_valid_q <= out_valid_d;
      out_sad_q   <= out_sad_d;
      out_idx_q   <= out_idx_d;
    end
  end

  // ------------------------------------------------------------ min tracker
  logic             best_valid_d, best_valid_q;
  logic [ACC_W-1:0] best_sad_d, best_sad_q;
  logic [IDX_W-1:0] best_idx_d, best_idx_q;

  // Keep the strictly smaller SAD; a clear wins over a concurrent candidate.
  always_comb begin
    best_valid_d = best_valid_q;
    best_sad_d   = best_sad_q;
    best_idx_d   = best_idx_q;
    if (search_clr) begin
      best_valid_d = 1'b0;
      best_sad_d   = {ACC_W{1'b1}};
      best_idx_d   = '0;
    end else if (out_valid_q && (!best_valid_q || (out_sad_q < best_sad_q))) begin
      best_valid_d = 1'b1;
      best_sad_d   = out_sad_q;
      best_idx_d   = out_idx_q;
    end
  end

  // Best-candidate registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_valid_q <= 1'b0;
      best_sad_q   <= {ACC_W{1'b1}};
      best_idx_q   <= '0;
    end else begin
      best_valid_q <= best_valid_d;
      best_sad_q   <= best_sad_d;
      best_idx_q   <= best_idx_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sad    = out_sad_q;
  assign out_idx    = out_idx_q;
  assign best_valid = best_valid_q;
  assign best_sad   = best_sad_q;
  assign best_idx   = best_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_sad_tree_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sad_tree_acc
//  Brief    : Directed self-checking bench for sad_tree_acc (N_IN=64, DW=8),
//             with a second instance at ACC_EXTRA=0 for saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sad_tree_acc;

  localparam int N_IN   = 64;
  localparam int DW     = 8;
  localparam int IDX_W  = 8;
  localparam int ACC_W  = 18;
  localparam int ACC_W2 = 14;
  localparam int LAT    = 4;   // edges from beat capture to out_valid

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_first;
  logic                 in_last;
  logic [N_IN*DW-1:0]   in_data;
  logic [IDX_W-1:0]     in_idx;
  logic                 search_clr;

  logic                 out_valid;
  logic [ACC_W-1:0]     out_sad;
  logic [IDX_W-1:0]     out_idx;
  logic                 best_valid;
  logic [ACC_W-1:0]     best_sad;
  logic [IDX_W-1:0]     best_idx;

  logic                 out_valid2;
  logic [ACC_W2-1:0]    out_sad2;
  logic [IDX_W-1:0]     out_idx2;
  logic                 best_valid2;
  logic [ACC_W2-1:0]    best_sad2;
  logic [IDX_W-1:0]     best_idx2;

  sad_tree_acc #(.N_IN(N_IN), .DW(DW), .ACC_EXTRA(4), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .in_data(in_data), .in_idx(in_idx),
    .search_clr(search_clr), .out_valid(out_valid), .out_sad(out_sad),
    .out_idx(out_idx), .best_valid(best_valid), .best_sad(best_sad),
    .best_idx(best_idx)
  );

  sad_tree_acc #(.N_IN(N_IN), .DW(DW), .ACC_EXTRA(0), .IDX_W(IDX_W)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .in_data(in_data), .in_idx(in_idx),
    .search_clr(search_clr), .out_valid(out_valid2), .out_sad(out_sad2),
    .out_idx(out_idx2), .best_valid(best_valid2), .best_sad(best_sad2),
    .best_idx(best_idx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int sad;
    int idx;
    int cyc;
  } pulse_t;

  pulse_t q[$];
  pulse_t mon_p;

  // Every out_valid pulse is logged with the cycle it was seen in.
  always @(negedge clk) begin
    if (out_valid) begin
      mon_p.sad = int'(out_sad);
      mon_p.idx = int'(out_idx);
      mon_p.cyc = cyc;
      q.push_back(mon_p);
    end
  end

  typedef struct {
    logic [7:0] fill;
    logic [7:0] lane0;
    logic [7:0] idx;
    int         exp_sad;
  } vec_t;

  vec_t tbl [7];
  int   e_tab [7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic beat(input logic v, input logic f, input logic l,
                      input logic [7:0] fill, input logic [7:0] lane0,
                      input logic [7:0] idx, output int e);
    in_valid = v;
    in_first = f;
    in_last  = l;
    in_data  = {N_IN{fill}};
    in_data[7:0] = lane0;
    in_idx   = idx;
    @(posedge clk);
    #1;
    e = cyc;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    search_clr = 1'b1;
    @(posedge clk);
    #1;
    search_clr = 1'b0;
  endtask

  task automatic expect_pulse(input string name, input int sad, input int idx, input int ecyc);
    pulse_t p;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no out_valid pulse, expected sad=%0d idx=%0d", name, sad, idx);
    end else begin
      p = q.pop_front();
      chk({name, "_sad"}, p.sad, sad);
      chk({name, "_idx"}, p.idx, idx);
      chk({name, "_cycle"}, p.cyc, ecyc);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_out_valid"},  out_valid, 0);
    chk({name, "_out_sad"},    out_sad, 0);
    chk({name, "_out_idx"},    out_idx, 0);
    chk({name, "_best_valid"}, best_valid, 0);
    chk({name, "_best_sad"},   best_sad, 262143);
    chk({name, "_best_idx"},   best_idx, 0);
  endtask

  initial begin
    int e;
    int e2;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_first   = 1'b0;
    in_last    = 1'b0;
    in_data    = '0;
    in_idx     = '0;
    search_clr = 1'b0;

    // Single-beat blocks, search started fresh: 63*fill + lane0.
    tbl[0] = '{8'h00, 8'd100, 8'd0, 100};
    tbl[1] = '{8'h00, 8'd50,  8'd1, 50};
    tbl[2] = '{8'h00, 8'd50,  8'd2, 50};
    tbl[3] = '{8'h00, 8'd70,  8'd3, 70};
    tbl[4] = '{8'h03, 8'h03,  8'd4, 192};
    tbl[5] = '{8'h00, 8'hFF,  8'd5, 255};
    tbl[6] = '{8'h10, 8'h00,  8'd6, 1008};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Single beat of all 0xFF.
    clr_pulse();
    beat(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'd3, e);
    idle(6);
    expect_pulse("t1", 16320, 3, e + LAT);
    chk("t1_best_valid", best_valid, 1);
    chk("t1_best_sad",   best_sad, 16320);
    chk("t1_best_idx",   best_idx, 3);

    // Four-beat block of 0x01 with an invalid garbage cycle in the middle.
    beat(1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 8'h55, e);
    beat(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h66, e);
    beat(1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 8'h55, e);
    beat(1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 8'h55, e);
    beat(1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 8'd7, e);
    idle(6);
    expect_pulse("t2", 256, 7, e + LAT);
    chk("t2_one_pulse", q.size(), 0);

    // A new first abandons an open block.
    beat(1'b1, 1'b1, 1'b0, 8'h05, 8'h05, 8'h11, e);
    beat(1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 8'h22, e);
    idle(6);
    expect_pulse("abandon", 64, 8'h22, e + LAT);

    // Back-to-back candidates from the table, fresh search.
    clr_pulse();
    for (int i = 0; i < 7; i++) begin
      beat(1'b1, 1'b1, 1'b1, tbl[i].fill, tbl[i].lane0, tbl[i].idx, e_tab[i]);
    end
    idle(6);
    for (int i = 0; i < 7; i++) begin
      expect_pulse($sformatf("tbl%0d", i), tbl[i].exp_sad, int'(tbl[i].idx), e_tab[i] + LAT);
    end
    chk("t3_best_valid", best_valid, 1);
    chk("t3_best_sad",   best_sad, 50);
    chk("t3_best_idx",   best_idx, 1);

    // Two-beat block of 0xFF: wide accumulator holds it, narrow one saturates.
    beat(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'd8, e);
    beat(1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'd8, e);
    idle(6);
    expect_pulse("t4", 32640, 8, e + LAT);
    chk("t4_sat_sad", out_sad2, 16383);
    chk("t4_best_sad_kept", best_sad, 50);
    chk("t4_best_idx_kept", best_idx, 1);

    // Reset in the middle of a block discards it.
    beat(1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 8'd0, e);
    beat(1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 8'd0, e);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_outputs("t5_reset");
    idle(6);
    chk("t5_no_pulse", q.size(), 0);
    beat(1'b1, 1'b0, 1'b1, 8'h02, 8'h02, 8'h21, e);
    idle(6);
    expect_pulse("t5", 128, 8'h21, e + LAT);
    chk("t5_best_sad", best_sad, 128);

    // search_clr concurrent with the best-stage update drops the candidate.
    beat(1'b1, 1'b1, 1'b1, 8'h00, 8'd10, 8'h0A, e);
    idle(4);
    chk("t6_pulse_now", out_valid, 1);
    clr_pulse();
    chk("t6_best_valid", best_valid, 0);
    chk("t6_best_sad",   best_sad, 262143);
    chk("t6_best_idx",   best_idx, 0);
    beat(1'b1, 1'b1, 1'b1, 8'h00, 8'd20, 8'h0C, e2);
    idle(6);
    expect_pulse("t6a", 10, 8'h0A, e + LAT);
    expect_pulse("t6b", 20, 8'h0C, e2 + LAT);
    chk("t6_best_valid_after", best_valid, 1);
    chk("t6_best_sad_after",   best_sad, 20);
    chk("t6_best_idx_after",   best_idx, 8'h0C);

    chk("no_extra_pulses", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
